register_file_multiport_sb: RTL and testbench
=============================================

# register_file_multiport_sb

Parametrised multi-write, multi-read register file with registered reads, write-port conflict resolution, an optional hardwired zero register, and a per-register busy scoreboard. It is the next generation of the team's LUT register file, and sits between issue/rename and execute. Consumers read operands one cycle after requesting them, together with a pending flag that shows whether each value is still awaiting a producer write.

## Interface
- DATA_WIDTH, 8, bits per register
- REG_COUNT, 16, number of registers (power of two, ≥2)
- WRITE_PORTS, 4, number of write ports
- READ_PORTS, 8, number of read ports
- ZERO_REG_EN, 0, 1 = register 0 always reads 0, ignores writes and is never busy
- ADDR_WIDTH (localparam), $clog2(REG_COUNT)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- clk_en  in  1  global enable; when 0 all state holds
- wr_en  in  WRITE_PORTS  per-port write request
- wr_addr  in  ADDR_WIDTH*WRITE_PORTS  packed; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- wr_data  in  DATA_WIDTH*WRITE_PORTS  packed; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- rd_en  in  READ_PORTS  per-port read request
- rd_addr  in  ADDR_WIDTH*READ_PORTS  packed, same slicing as wr_addr
- rd_data  out  DATA_WIDTH*READ_PORTS  registered read data
- rd_valid  out  READ_PORTS  rd_data slice updated at the last enabled edge
- rd_pending  out  READ_PORTS  read register was busy when sampled
- alloc_en  in  1  mark alloc_addr busy (a producer is in flight)
- alloc_addr  in  ADDR_WIDTH  register to mark busy
- busy  out  REG_COUNT  scoreboard, bit r = register r awaits a write

## Operation
- Reset: every register, busy, rd_data, rd_valid and rd_pending go to 0 immediately, with no clock edge needed.
- All state updates only on a rising edge with clk_en=1.
- Write: each port with wr_en[i]=1 writes wr_data slice i to wr_addr slice i.
- Write conflict: when several ports target one register, the highest-indexed port wins and the other writes are discarded.
- Busy clear: a write to register r clears busy[r].
- Busy set: alloc_en=1 sets busy[alloc_addr].
- Alloc and write to the same register on the same edge: data is written and busy ends at 1 (alloc wins).
- Alloc on an already busy register: busy stays 1, no error.
- Read: for each port with rd_en[j]=1, the edge captures the register contents into the rd_data slice, captures busy into rd_pending[j], and sets rd_valid[j]=1.
- Read with rd_en[j]=0 on an enabled edge: rd_valid[j]=0; rd_data and rd_pending for that port hold.
- Reads never block; any number of ports may read the same address.
- ZERO_REG_EN=1: writes and allocs to register 0 are ignored; reads of register 0 return 0 with pending 0.
- Out-of-range addresses cannot occur because REG_COUNT is a power of two.

## Timing
- Write latency is 1 edge; the data is visible to reads sampled at the following edge, or at the same edge when bypass is compiled in.
- Read latency is 1 edge from rd_en/rd_addr to rd_data/rd_valid/rd_pending.
- Scoreboard latency is 1 edge; busy is a registered output.
- clk_en=0: nothing changes, including rd_valid; consumers qualify rd_valid with clk_en.
- Reset asserted mid-operation discards in-flight reads; rd_valid is 0 on the first edge after release.

## Configuration
- Macro `REGFILE_BYPASS_EN`, compiled in by default in the team flow.
- Defined: a read sampling register r on the same edge as a winning write to r returns the new wr_data with rd_pending=0, even if an alloc to r coincides.
- Undefined: the same read returns the pre-edge contents and the pre-edge busy bit.
- ZERO_REG_EN takes precedence over bypass for register 0.

## Structure
- Package `regfile_pkg`:
  - function `rf_slice_idx(port, width)` for packed slicing;
  - a typedef for the write-resolution result (valid, data, per register).
- Sub-module `regfile_write_resolve`: combinational; per register, selects the highest-indexed matching write port and outputs {hit, data}. Both the write path and the bypass path reuse it.
- Top: storage array, scoreboard vector, read capture registers.

## Test plan
- Reset and basic read: assert rst mid-run → all outputs 0 without a clock edge; after release, read r5 → rd_data=0, rd_valid=1 one edge later.
- Write conflict: ports 0/2/3 write r7 with 0x11/0x22/0x33 → read r7 returns 0x33.
- Bypass, same edge: write r3=0xA5 and read r3. With `REGFILE_BYPASS_EN` → 0xA5, pending=0. Without it → previous value 0x00.
- Scoreboard: alloc r9 → busy[9]=1, read r9 gives pending=1; later write r9=0x5C → busy[9]=0. Alloc and write r9 on the same edge → busy[9]=1, data 0x5C.
- Zero register: with ZERO_REG_EN=1, write r0=0xFF and alloc r0 → read r0=0, pending=0, busy[0]=0.
- clk_en hold: hold clk_en=0 for 3 edges while driving writes/reads/alloc → rd_data, rd_valid, busy and storage are unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file.
package regfile_pkg;

    // Upper bound on DATA_WIDTH carried by the write-resolution result.
    localparam int unsigned RF_MAX_DATA_WIDTH = 64;

    typedef struct packed {
        logic                         hit;
        logic [RF_MAX_DATA_WIDTH-1:0] data;
    } rf_wres_t;

    function automatic int unsigned rf_slice_idx(input int unsigned port,
                                                 input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_write_resolve.sv
// Per-register write resolution: the highest-indexed matching write port wins.
module regfile_write_resolve
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned REG_COUNT   = 16,
    parameter int unsigned WRITE_PORTS = 4,
    localparam int unsigned ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic [WRITE_PORTS-1:0]            wr_en,
    input  logic [ADDR_WIDTH*WRITE_PORTS-1:0] wr_addr,
    input  logic [DATA_WIDTH*WRITE_PORTS-1:0] wr_data,
    output rf_wres_t                          res [REG_COUNT]
);

    always_comb begin
        for (int unsigned r = 0; r < REG_COUNT; r++) begin
            res[r] = '0;
            // Later ports overwrite earlier matches, so the highest index wins.
            for (int unsigned i = 0; i < WRITE_PORTS; i++) begin
                if (wr_en[i] &&
                    wr_addr[rf_slice_idx(i, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    res[r].hit                   = 1'b1;
                    res[r].data[DATA_WIDTH-1:0]  =
                        wr_data[rf_slice_idx(i, DATA_WIDTH) +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/register_file_multiport_sb.sv
// Multi-write/multi-read register file with registered reads and busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-edge winning writes to reads.
module register_file_multiport_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned REG_COUNT   = 16,
    parameter int unsigned WRITE_PORTS = 4,
    parameter int unsigned READ_PORTS  = 8,
    parameter bit          ZERO_REG_EN = 1'b0,
    localparam int unsigned ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clk_en,
    input  logic [WRITE_PORTS-1:0]          wr_en,
    input  logic [ADDR_WIDTH*WRITE_PORTS-1:0] wr_addr,
    input  logic [DATA_WIDTH*WRITE_PORTS-1:0] wr_data,
    input  logic [READ_PORTS-1:0]           rd_en,
    input  logic [ADDR_WIDTH*READ_PORTS-1:0] rd_addr,
    output logic [DATA_WIDTH*READ_PORTS-1:0] rd_data,
    output logic [READ_PORTS-1:0]           rd_valid,
    output logic [READ_PORTS-1:0]           rd_pending,
    input  logic                            alloc_en,
    input  logic [ADDR_WIDTH-1:0]           alloc_addr,
    output logic [REG_COUNT-1:0]            busy
);

    rf_wres_t                 wres [REG_COUNT];
    logic [DATA_WIDTH-1:0]    mem_q [REG_COUNT];
    logic [DATA_WIDTH-1:0]    mem_d [REG_COUNT];
    logic [REG_COUNT-1:0]     busy_q, busy_d;
    logic [DATA_WIDTH*READ_PORTS-1:0] rd_data_q, rd_data_d;
    logic [READ_PORTS-1:0]    rd_valid_q, rd_valid_d;
    logic [READ_PORTS-1:0]    rd_pending_q, rd_pending_d;
    logic [RF_MAX_DATA_WIDTH-1:0] unused_wres_data;

    regfile_write_resolve #(
        .DATA_WIDTH  (DATA_WIDTH),
        .REG_COUNT   (REG_COUNT),
        .WRITE_PORTS (WRITE_PORTS)
    ) u_write_resolve (
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .res     (wres)
    );

    always_comb begin
        unused_wres_data = '0;
        for (int unsigned r = 0; r < REG_COUNT; r++) begin
            unused_wres_data = unused_wres_data ^ wres[r].data;
            mem_d[r]  = mem_q[r];
            busy_d[r] = busy_q[r];
            if (wres[r].hit) begin
                mem_d[r]  = wres[r].data[DATA_WIDTH-1:0];
                busy_d[r] = 1'b0;
            end
            // Alloc is applied after the write so a coincident alloc leaves the register busy.
            if (alloc_en && alloc_addr == ADDR_WIDTH'(r)) begin
                busy_d[r] = 1'b1;
            end
            if (ZERO_REG_EN && r == 0) begin
                mem_d[r]  = '0;
                busy_d[r] = 1'b0;
            end
        end
    end

    always_comb begin
        logic [ADDR_WIDTH-1:0] a;
        a            = '0;
        rd_data_d    = rd_data_q;
        rd_pending_d = rd_pending_q;
        rd_valid_d   = rd_en;
        for (int unsigned j = 0; j < READ_PORTS; j++) begin
            a = rd_addr[rf_slice_idx(j, ADDR_WIDTH) +: ADDR_WIDTH];
            if (rd_en[j]) begin
                rd_data_d[rf_slice_idx(j, DATA_WIDTH) +: DATA_WIDTH] = mem_q[a];
                rd_pending_d[j] = busy_q[a];
`ifdef REGFILE_BYPASS_EN
                if (wres[a].hit) begin
                    rd_data_d[rf_slice_idx(j, DATA_WIDTH) +: DATA_WIDTH] =
                        wres[a].data[DATA_WIDTH-1:0];
                    rd_pending_d[j] = 1'b0;
                end
`endif
                if (ZERO_REG_EN && a == '0) begin
                    rd_data_d[rf_slice_idx(j, DATA_WIDTH) +: DATA_WIDTH] = '0;
                    rd_pending_d[j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) begin
                mem_q[r] <= '0;
            end
            busy_q       <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= '0;
            rd_pending_q <= '0;
        end else if (clk_en) begin
            for (int unsigned r = 0; r < REG_COUNT; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q       <= busy_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_pending = rd_pending_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_register_file_multiport_sb.sv
// Directed bench for register_file_multiport_sb; dut has no zero register, dutz has one.
module tb_register_file_multiport_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst, clk_en;
    logic [3:0]  wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_en;
    logic [31:0] rd_addr;
    logic        alloc_en;
    logic [3:0]  alloc_addr;

    logic [63:0] rd_data, rd_data_z;
    logic [7:0]  rd_valid, rd_valid_z, rd_pending, rd_pending_z;
    logic [15:0] busy, busy_z;

    int vectors = 0;
    int miscompares = 0;

    register_file_multiport_sb #(.ZERO_REG_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_pending(rd_pending),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy)
    );

    register_file_multiport_sb #(.ZERO_REG_EN(1'b1)) dutz (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_z), .rd_valid(rd_valid_z), .rd_pending(rd_pending_z),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy(busy_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        rd_en    = '0;
        alloc_en = 1'b0;
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [7:0] d);
        wr_en[p]           = 1'b1;
        wr_addr[p*4 +: 4]  = a;
        wr_data[p*8 +: 8]  = d;
    endtask

    task automatic rd(input int p, input logic [3:0] a);
        rd_en[p]           = 1'b1;
        rd_addr[p*4 +: 4]  = a;
    endtask

    task automatic alloc(input logic [3:0] a);
        alloc_en   = 1'b1;
        alloc_addr = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1;
        wr_addr = '0; wr_data = '0; rd_addr = '0; alloc_addr = '0;
        idle();
        #1;
        chk("init_busy", 64'(busy), 64'h0);
        chk("init_valid", 64'(rd_valid), 64'h0);
        tick(); tick();
        rst = 1'b0;

        // Build some state, then reset asynchronously between edges
        wr(0, 4'd1, 8'h12); alloc(4'd2);
        tick();
        idle(); rd(0, 4'd1); rd(1, 4'd2);
        tick();
        chk("pre_rst_data", rd_data[15:0], 64'h0012);
        chk("pre_rst_pend", 64'(rd_pending), 64'h02);
        chk("pre_rst_busy", 64'(busy), 64'h0004);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data", rd_data, 64'h0);
        chk("async_rst_valid", 64'(rd_valid), 64'h0);
        chk("async_rst_pend", 64'(rd_pending), 64'h0);
        chk("async_rst_busy", 64'(busy), 64'h0);
        idle();
        tick();
        rst = 1'b0;
        chk("post_rst_valid", 64'(rd_valid), 64'h0);
        rd(0, 4'd5); rd(1, 4'd1);
        tick();
        chk("read_r5_r1_data", rd_data[15:0], 64'h0000);
        chk("read_r5_valid", 64'(rd_valid), 64'h03);

        // Write conflict on r7: port 3 wins
        idle(); wr(0, 4'd7, 8'h11); wr(2, 4'd7, 8'h22); wr(3, 4'd7, 8'h33); wr(1, 4'd6, 8'h44);
        tick();
        idle(); rd(0, 4'd7); rd(1, 4'd6);
        tick();
        chk("conflict_r7", rd_data[7:0], 64'h33);
        chk("port1_r6", rd_data[15:8], 64'h44);

        // Same-edge write and read of r3
        idle(); wr(0, 4'd3, 8'hA5); rd(2, 4'd3);
        tick();
        chk("same_edge_r3", rd_data[23:16], BYP ? 64'hA5 : 64'h00);
        chk("same_edge_r3_pend", 64'(rd_pending[2]), 64'h0);
        idle(); rd(2, 4'd3);
        tick();
        chk("later_r3", rd_data[23:16], 64'hA5);
        chk("valid_only_p2", 64'(rd_valid), 64'h04);
        chk("p0_data_held", rd_data[7:0], 64'h33);

        // Scoreboard on r9
        idle(); alloc(4'd9);
        tick();
        chk("alloc_busy", 64'(busy), 64'h0200);
        idle(); rd(0, 4'd9);
        tick();
        chk("busy_read_pend", 64'(rd_pending[0]), 64'h1);
        idle(); wr(1, 4'd9, 8'h5C); rd(3, 4'd9);
        tick();
        chk("write_clears_busy", 64'(busy), 64'h0);
        chk("wr_rd_r9_data", rd_data[31:24], BYP ? 64'h5C : 64'h00);
        chk("wr_rd_r9_pend", 64'(rd_pending[3]), BYP ? 64'h0 : 64'h1);
        idle(); alloc(4'd9); wr(2, 4'd9, 8'h6D); rd(4, 4'd9);
        tick();
        chk("alloc_wins_busy", 64'(busy), 64'h0200);
        chk("alloc_wr_same_rd", rd_data[39:32], BYP ? 64'h6D : 64'h5C);
        chk("alloc_wr_same_pend", 64'(rd_pending[4]), 64'h0);
        idle(); alloc(4'd9); rd(0, 4'd9);
        tick();
        chk("realloc_busy", 64'(busy), 64'h0200);
        chk("alloc_wr_data", rd_data[7:0], 64'h6D);
        chk("alloc_wr_pend", 64'(rd_pending[0]), 64'h1);

        // Register 0: plain on dut, hardwired zero on dutz
        idle(); wr(3, 4'd0, 8'hFF); alloc(4'd0); rd(5, 4'd0);
        tick();
        chk("r0_busy", 64'(busy), 64'h0201);
        chk("r0z_busy", 64'(busy_z), 64'h0200);
        chk("r0_same_edge", rd_data[47:40], BYP ? 64'hFF : 64'h00);
        chk("r0z_same_edge", rd_data_z[47:40], 64'h00);
        idle(); rd(5, 4'd0);
        tick();
        chk("r0_data", rd_data[47:40], 64'hFF);
        chk("r0_pend", 64'(rd_pending[5]), 64'h1);
        chk("r0z_data", rd_data_z[47:40], 64'h00);
        chk("r0z_pend", 64'(rd_pending_z[5]), 64'h0);

        // Hold with clk_en low
        idle(); clk_en = 1'b0;
        wr(0, 4'd4, 8'hAB); alloc(4'd4); rd(0, 4'd4); rd(6, 4'd7);
        tick(); tick(); tick();
        chk("hold_valid", 64'(rd_valid), 64'h20);
        chk("hold_data", rd_data[47:40], 64'hFF);
        chk("hold_busy", 64'(busy), 64'h0201);
        chk("hold_busy_z", 64'(busy_z), 64'h0200);
        clk_en = 1'b1;
        idle(); rd(0, 4'd4);
        tick();
        chk("hold_storage", rd_data[7:0], 64'h00);
        chk("hold_storage_pend", 64'(rd_pending[0]), 64'h0);
        chk("resume_valid", 64'(rd_valid), 64'h01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
